// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the execution units.
//   XLEN           : register width (only 32 is supported)
//   F3_*           : funct3 encodings of the M-extension operations
//   muldiv_state_t : control states of the iterative multiply/divide unit
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_PREP,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue / writeback bundle between the core pipeline and muldiv_unit.
//   master (pipeline): drives start, op, rs1_val, rs2_val, rd;
//                      observes busy, done, result, wb_rd, wb_en
//   slave  (unit)    : the mirror image
interface muldiv_unit_if
  import riscv_pkg::*;
;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      wb_rd;
  logic            wb_en;

  modport master (
    output start, op, rs1_val, rs2_val, rd,
    input  busy, done, result, wb_rd, wb_en
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd,
    output busy, done, result, wb_rd, wb_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of muldiv_unit_if
//           start/op/rs1_val/rs2_val/rd in; busy/done/result/wb_rd/wb_en out
// One radix-2 step per CALC cycle (32 steps); normal latency 34 cycles,
// divide-by-zero and signed overflow finish in 2.
module muldiv_unit
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  muldiv_state_t     state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;          // multiplicand / dividend (magnitude in CALC)
  logic [XLEN-1:0]   b_q, b_d;          // multiplier / divisor (magnitude in CALC)
  logic [2*XLEN-1:0] acc_q, acc_d;      // product, or {remainder, quotient}
  logic [4:0]        count_q, count_d;
  logic              neg_q, neg_d;      // product / quotient sign
  logic              rem_neg_q, rem_neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        wb_rd_q, wb_rd_d;

  logic accept, is_div, rs1_signed, rs2_signed, a_neg, b_neg, div_zero, div_ovf;

  assign accept     = bus.start && (state_q == MD_IDLE || state_q == MD_DONE);
  assign is_div     = op_q[2];
  assign rs1_signed = (op_q == F3_MULH) || (op_q == F3_MULHSU) ||
                      (op_q == F3_DIV)  || (op_q == F3_REM);
  assign rs2_signed = (op_q == F3_MULH) || (op_q == F3_DIV) || (op_q == F3_REM);
  assign a_neg      = rs1_signed && a_q[XLEN-1];
  assign b_neg      = rs2_signed && b_q[XLEN-1];
  assign div_zero   = is_div && (b_q == '0);
  assign div_ovf    = is_div && rs1_signed &&
                      (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  // Shared 33-bit adder: multiply adds the gated multiplicand to the upper
  // product half; divide subtracts the divisor from the shifted remainder.
  // Bit 33 of the subtract is the borrow (shifted remainder < divisor).
  logic [XLEN:0]   add_x, add_y;
  logic [XLEN+1:0] add_sum;
  assign add_x   = is_div ? {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]}
                          : {1'b0, acc_q[2*XLEN-1:XLEN]};
  assign add_y   = is_div ? {1'b0, b_q}
                          : (b_q[0] ? {1'b0, a_q} : '0);
  assign add_sum = {1'b0, add_x} + ({1'b0, add_y} ^ {(XLEN+2){is_div}})
                 + {{(XLEN+1){1'b0}}, is_div};

  // Sign-corrected views used in FIX; special-case results are stored pre-signed.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = (neg_q && !special_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = (rem_neg_q && !special_q) ? -acc_q[2*XLEN-1:XLEN]
                                              : acc_q[2*XLEN-1:XLEN];

  // NOTE: every variable gets a default at the top of the combinational
  // block, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    special_d = special_q;
    result_d  = result_q;
    wb_rd_d   = wb_rd_q;

    unique case (state_q)
      MD_PREP: begin
        if (div_zero) begin
          acc_d     = {a_q, 32'hFFFF_FFFF};
          special_d = 1'b1;
          state_d   = MD_FIX;
        end else if (div_ovf) begin
          acc_d     = {32'h0000_0000, 32'h8000_0000};
          special_d = 1'b1;
          state_d   = MD_FIX;
        end else begin
          a_d       = a_neg ? -a_q : a_q;
          b_d       = b_neg ? -b_q : b_q;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          special_d = 1'b0;
          acc_d     = '0;
          count_d   = '0;
          state_d   = MD_CALC;
        end
      end
      MD_CALC: begin
        if (is_div) begin
          // Restore on borrow: keep the shifted remainder, quotient bit 0.
          acc_d = {add_sum[XLEN+1] ? add_x[XLEN-1:0] : add_sum[XLEN-1:0],
                   acc_q[XLEN-2:0], ~add_sum[XLEN+1]};
          a_d   = a_q << 1;
        end else begin
          acc_d = {add_sum[XLEN:0], acc_q[XLEN-1:1]};
          b_d   = b_q >> 1;
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = MD_FIX;
      end
      MD_FIX: begin
        unique case (op_q)
          F3_MUL:                       result_d = prod_fix[XLEN-1:0];
          F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          F3_DIV, F3_DIVU:              result_d = quo_fix;
          default:                      result_d = rem_fix;
        endcase
        state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase

    // Acceptance in IDLE or DONE overrides the default transition above.
    if (accept) begin
      op_d    = bus.op;
      a_d     = bus.rs1_val;
      b_d     = bus.rs2_val;
      wb_rd_d = bus.rd;
      state_d = MD_PREP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
      wb_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      special_q <= special_d;
      result_q  <= result_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  assign bus.busy   = (state_q == MD_PREP) || (state_q == MD_CALC) || (state_q == MD_FIX);
  assign bus.done   = (state_q == MD_DONE);
  assign bus.result = result_q;
  assign bus.wb_rd  = wb_rd_q;
  assign bus.wb_en  = bus.done && (wb_rd_q != 5'd0);

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It accepts one M-extension operation with both operand values and a destination register number, then computes the result over multiple cycles. It presents a one-cycle writeback beat (`wb_en`, `wb_rd`, `result`) that feeds the register file write port (`RegWrite`, `Write_Reg_Num`, `WriteData`). The core pipeline stalls on `busy`.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request. Sampled only when the unit can accept (IDLE or DONE).
- `op` input 3: funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val` input 32: multiplicand / dividend.
- `rs2_val` input 32: multiplier / divisor.
- `rd` input 5: destination register.
- `busy` output 1: high in PREP, CALC and FIX.
- `done` output 1: one-cycle pulse; `result` is valid during it.
- `result` output 32: computed value. Holds its value until the next DONE or reset.
- `wb_rd` output 5: latched `rd`.
- `wb_en` output 1: equals `done` when `wb_rd` is nonzero; otherwise low. Register 0 is never written.

## Operation
- States:
  - IDLE: `start` moves to PREP. Latch `op`, `rd`, `rs1_val` and `rs2_val`.
  - PREP: take absolute values for signed forms. Record result sign.
    - Detect the special cases (divide by zero; signed overflow, 0x80000000 / 0xFFFFFFFF).
    - Special case: go to FIX. Otherwise clear the 64-bit accumulator, set `count` = 0 and go to CALC.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add into a 64-bit product.
    - Divide: restoring shift-subtract, with a 33-bit partial remainder.
    - After the step with `count` = 31, go to FIX.
  - FIX: apply sign correction and select the word. Register `result`, then go to DONE.
    - MUL: low word.
    - MULH, MULHSU, MULHU: high word.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - DONE: `done` = 1. A `start` here is accepted, goes to PREP and latches new operands. Otherwise go to IDLE.
- Sign rules:
  - MULHSU treats only `rs1` as signed.
  - Negate the 64-bit product when exactly one signed operand is negative.
  - Quotient sign is the XOR of the operand signs. Remainder sign is the dividend sign.
- Special cases (RISC-V spec):
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
  - Multiply has no special cases.
- `start` outside IDLE/DONE is ignored. No queueing, no error flag.
- Operand inputs may change freely after acceptance.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `wb_en` 0, `result` 0x00000000, `wb_rd` 0, `count` 0.
- Let edge N be the edge that accepts `start`.
- Normal operation: PREP after N, CALC after N+1 through N+32, FIX after N+33, `done` high in the cycle after edge N+34. Latency is 34 cycles.
- Special case: FIX after N+1, `done` high after edge N+2. Latency is 2 cycles.
- `busy` rises in the cycle after edge N and falls in the DONE cycle.
- Back-to-back: a `start` during DONE gives `busy` high in the next cycle, with no IDLE gap.
- Reset asserted mid-operation returns all outputs to reset values at the next edge. No partial writeback is emitted.
- Reset and `start` in the same cycle: reset wins.

## Structure
- Shared package `riscv_pkg` holds:
  - `localparam`s for the funct3 muldiv op codes.
  - The `muldiv_state_t` enum (IDLE, PREP, CALC, FIX, DONE).
  - `XLEN`.
- Single module; no sub-module. The CALC datapath is one shared 33-bit adder/subtractor selected by multiply vs divide.

## Test plan
- MUL 7 × 0xFFFFFFFD, `rd` = 5: `result` 0xFFFFFFEB, `wb_en` = 1, `wb_rd` = 5, `done` exactly 34 cycles after the accept edge.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 gives 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 gives 0xFFFFFFFD. REM of the same gives 0xFFFFFFFF. DIVU 100 / 7 gives 14. REMU 100 / 7 gives 2.
- Special cases, each with `done` after 2 cycles:
  - DIVU 5 / 0 gives 0xFFFFFFFF.
  - REM 5 / 0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000.
  - REM of the same gives 0.
- Control sequence:
  - A `start` at cycle 10 of CALC is ignored, with the result unchanged.
  - A `start` in the DONE cycle is accepted with no idle gap.
  - With `rd` = 0: `done` = 1 and `wb_en` = 0.
- Reset asserted at CALC `count` 15: next cycle is IDLE with all outputs at reset values and no `done`. A new MUL 3 × 4 then returns 12.
